// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the iterative multiply/divide unit.
//   md_op_t     : 3-bit command encodings presented on muldiv_unit.op
//   mdu_state_t : sequencer states (IDLE, RUN, FIX, DONE)
//   MDU_STEPS   : radix-2 iterations per mult/div
//   MDU_DIVZ_Q  : quotient returned on divide by zero
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  localparam int          MDU_STEPS  = 32;
  localparam logic [31:0] MDU_DIVZ_Q = 32'hFFFFFFFF;

  // True for the four ops that go through the multi-cycle sequencer.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// div_step: one combinational restoring-division step.
//   rem_in  : partial remainder (always < divisor)
//   divisor : divisor magnitude
//   bit_in  : next dividend bit, MSB first
//   rem_out : updated partial remainder
//   q_bit   : quotient bit produced by this step
module div_step (
  input  logic [31:0] rem_in,
  input  logic [31:0] divisor,
  input  logic        bit_in,
  output logic [31:0] rem_out,
  output logic        q_bit
);

  // 33 bits so the trial compare never loses the carry out of rem_in.
  logic [32:0] shifted;

  assign shifted = {rem_in, bit_in};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // When q_bit is set the true difference is < divisor, so 32 bits suffice.
  assign rem_out = q_bit ? (shifted[31:0] - divisor) : shifted[31:0];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit owning the HI/LO registers.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   a, b       : rs/rt operands (dividend/multiplicand, divisor/multiplier)
//   op         : md_op_t command, start : command valid (sampled in IDLE)
//   busy       : operation in progress, done : one-cycle result pulse
//   hi, lo     : architectural HI/LO registers
// Build option: define MDU_FAST_MULT_EN to compute MULT/MULTU with a
// single-cycle multiplier (IDLE -> FIX); divide stays iterative.
module muldiv_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  function automatic logic [31:0] mag32(input logic signed [31:0] v);
    return v[31] ? (~v + 32'sd1) : v;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  mdu_state_t  state;
  logic [4:0]  count;

  // Command captured at accept
  md_op_t      op_p0;
  logic        neg_q_p0, neg_r_p0, divz_p0;
  logic [31:0] ma_p0, mb_p0, a_p0;
  logic [31:0] work_hi, work_lo;

  logic        accept, is_mul_in, is_signed_in, mul_p0;
  logic [31:0] ma_in, mb_in;
  logic [32:0] mul_sum;
  logic [31:0] rem_next;
  logic        q_bit;
  logic [63:0] prod_mag, prod_fix;
  logic [31:0] res_hi, res_lo;

  assign is_mul_in    = (op == MD_MULT) || (op == MD_MULTU);
  assign is_signed_in = (op == MD_MULT) || (op == MD_DIV);
  assign accept       = (state == IDLE) && start && is_muldiv(op);
  assign ma_in        = is_signed_in ? mag32(a) : a;
  assign mb_in        = is_signed_in ? mag32(b) : b;
  assign mul_p0       = (op_p0 == MD_MULT) || (op_p0 == MD_MULTU);

  // Multiply: {work_hi,work_lo} holds partial product over the shifting multiplier.
  assign mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, ma_p0} : 33'd0);

  // Divide: work_hi is the partial remainder, work_lo shifts dividend out / quotient in.
  div_step u_div_step (
    .rem_in  (work_hi),
    .divisor (mb_p0),
    .bit_in  (work_lo[31]),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  always_comb begin
`ifdef MDU_FAST_MULT_EN
    prod_mag = mul_p0 ? ({32'd0, ma_p0} * {32'd0, mb_p0}) : {work_hi, work_lo};
`else
    prod_mag = {work_hi, work_lo};
`endif
    prod_fix = neg_q_p0 ? neg64(prod_mag) : prod_mag;
    res_hi   = prod_fix[63:32];
    res_lo   = prod_fix[31:0];
    if (!mul_p0) begin
      if (divz_p0) begin
        res_hi = a_p0;
        res_lo = MDU_DIVZ_Q;
      end else begin
        res_lo = neg_q_p0 ? neg32(work_lo) : work_lo;
        res_hi = neg_r_p0 ? neg32(work_hi) : work_hi;
      end
    end
  end

  // Control and architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 5'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            count <= 5'd0;
`ifdef MDU_FAST_MULT_EN
            if (is_mul_in) begin
              state <= FIX;
            end else begin
              busy  <= 1'b1;
              state <= RUN;
            end
`else
            busy  <= 1'b1;
            state <= RUN;
`endif
          end else if (start && (op == MD_MTHI)) begin
            hi <= a;
          end else if (start && (op == MD_MTLO)) begin
            lo <= a;
          end
        end
        RUN: begin
          count <= count + 5'd1;
          if (count == 5'(MDU_STEPS - 1)) state <= FIX;
        end
        FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          busy  <= 1'b1;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: operand capture at accept, one radix-2 step per RUN cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0    <= md_op_t'(op);
      neg_q_p0 <= is_signed_in & (a[31] ^ b[31]);
      neg_r_p0 <= is_signed_in & a[31];
      divz_p0  <= (b == 32'd0);
      a_p0     <= a;
      ma_p0    <= ma_in;
      mb_p0    <= mb_in;
      work_hi  <= 32'd0;
      work_lo  <= is_mul_in ? mb_in : ma_in;
    end else if (state == RUN) begin
      if (mul_p0) begin
        work_hi <= mul_sum[32:1];
        work_lo <= {mul_sum[0], work_lo[31:1]};
      end else begin
        work_hi <= rem_next;
        work_lo <= {work_lo[30:0], q_bit};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table of mult/div vectors plus
// hand-written sequences for MTHI/MTLO, ignored start and mid-op reset.
module tb_muldiv_unit;
  import mdu_pkg::*;

  logic        clk, reset, start, busy, done;
  logic [31:0] a, b, hi, lo;
  logic [2:0]  op;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[10];

`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif

  muldiv_unit dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .start(start),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the unit idle again.
  task automatic run_op(input logic [2:0] o, input logic [31:0] ra, input logic [31:0] rb,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int inject, input string name);
    logic [31:0] h0, l0;
    logic [63:0] got, expv;
    int lat, exp_busy, bcnt, dcnt, dcyc;
    exp_q.push_back({ehi, elo});
    lat      = ((o == MD_MULT) || (o == MD_MULTU)) ? MUL_LAT : 34;
    exp_busy = (lat == 34) ? 34 : 1;
    h0 = hi; l0 = lo;
    start = 1'b1; op = o; a = ra; b = rb;
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    bcnt = 0; dcnt = 0; dcyc = 0; got = '0;
    for (int cyc = 1; cyc <= 44; cyc++) begin
      if (cyc == 1 || (cyc == 20 && lat > 20)) begin
        chk({name, "_hold_hi"}, 64'(hi), 64'(h0));
        chk({name, "_hold_lo"}, 64'(lo), 64'(l0));
      end
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (dcnt == 1) begin
          dcyc = cyc;
          got  = {hi, lo};
        end
      end
      if (cyc == inject) begin
        start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    expv = exp_q.pop_front();
    chk({name, "_result"},  got, expv);
    chk({name, "_latency"}, 64'(dcyc), 64'(lat));
    chk({name, "_dones"},   64'(dcnt), 64'd1);
    chk({name, "_busycyc"}, 64'(bcnt), 64'(exp_busy));
    chk({name, "_idle"},    64'(busy), 64'd0);
  endtask

  initial begin
    vecs[0] = '{MD_MULT,  32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4] = '{MD_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF};
    vecs[5] = '{MD_DIV,   32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2};
    vecs[6] = '{MD_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    vecs[7] = '{MD_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[8] = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[9] = '{MD_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF};

    reset = 1'b1; start = 1'b0; op = 3'd7; a = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi",   64'(hi),   64'd0);
    chk("reset_lo",   64'(lo),   64'd0);

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 0, $sformatf("vec%0d", i));

    // DIVU by zero, then MTHI / MTLO / undefined op
    run_op(MD_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 0, "divz");
    start = 1'b1; op = MD_MTHI; a = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    chk("mthi_hi",   64'(hi),   64'h1234);
    chk("mthi_lo",   64'(lo),   64'hFFFFFFFF);
    chk("mthi_done", 64'(done), 64'd0);
    chk("mthi_busy", 64'(busy), 64'd0);
    start = 1'b1; op = MD_MTLO; a = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h5678);
    chk("mtlo_hi", 64'(hi), 64'h1234);
    start = 1'b1; op = 3'd6; a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    chk("undef_hi",   64'(hi),   64'h1234);
    chk("undef_lo",   64'(lo),   64'h5678);
    chk("undef_busy", 64'(busy), 64'd0);

    // Second start while busy is ignored
    run_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10, "ignore");

    // Reset in the middle of a DIV
    start = 1'b1; op = MD_DIV; a = 32'd50; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi",   64'(hi),   64'd0);
    chk("midrst_lo",   64'(lo),   64'd0);
    reset = 1'b0;
    begin
      int dc = 0;
      for (int c = 0; c < 40; c++) begin
        if (done || busy) dc++;
        @(negedge clk);
      end
      chk("midrst_quiet", 64'(dc), 64'd0);
    end
    run_op(MD_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit holding the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside `alu` in the execute path and takes the same register-file operands `a`/`b`. Its `hi`/`lo` outputs feed the writeback mux for MFHI/MFLO. The controller must stall the PC while `busy` is high.

## Interface
- Parameters: none; width fixed at 32.
- Reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `a`  in  32  rs operand: dividend, multiplicand, or MTHI/MTLO source
- `b`  in  32  rt operand: divisor or multiplier
- `op`  in  3  `MD_MULT`=0, `MD_MULTU`=1, `MD_DIV`=2, `MD_DIVU`=3, `MD_MTHI`=4, `MD_MTLO`=5; others are no-op
- `start`  in  1  command valid, sampled only in IDLE
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse when `hi`/`lo` are updated by a mult/div
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- States:
  - IDLE: `start` with mult/div op → latch operands, sign flags and op; count=0 → RUN.
  - RUN: one radix-2 step per cycle (shift-add for multiply, restoring for divide), count++; after step 31 → FIX.
  - FIX: apply sign correction, write `hi`/`lo` → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Signed ops work on magnitudes; the result is negated in FIX.
  - MULT: 64-bit product negated if signs of `a` and `b` differ.
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend.
- Results: multiply gives {hi,lo} = 64-bit product; divide gives lo=quotient, hi=remainder.
- Divide by zero, DIV or DIVU: hi=`a`, lo=32'hFFFFFFFF. No trap.
- DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
- MTHI/MTLO in IDLE with `start`: write `hi`/`lo` at that edge. `busy` and `done` stay 0; state stays IDLE.
- `start` outside IDLE is ignored; no queueing.
- Undefined `op` with `start`: no effect.
- `hi`/`lo` are unchanged during RUN/FIX until the FIX edge. Reads during `busy` return the previous values.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, count=0.
- Reset mid-operation: abort at the next edge and apply reset values. The partial result is discarded.
- Let the mult/div `start` be accepted at edge E0:
  - `busy`=1 from after E0 through the cycle after E0+33.
  - FIX edge is E0+33; `hi`/`lo` are new from after E0+33.
  - `done`=1 only in the cycle after E0+33; `busy` is also 1 in that cycle.
  - `busy`=0 after E0+34. A new `start` can be accepted at E0+34 + 1 cycle (IDLE).
- Total latency: 34 cycles from accept to result.
- MTHI/MTLO latency: result visible the cycle after the accepting edge.
- `busy` and `done` are registered outputs; there is no combinational path from `start`.

## Configuration
- `MDU_FAST_MULT_EN`
  - Defined: MULT/MULTU go IDLE → FIX directly and use a single-cycle 64-bit multiplier. `hi`/`lo` are written at E0+1, with `done` in the cycle after E0+1 and `busy` high only in that cycle. Divide timing is unchanged.
  - Undefined: all mult/div ops use the 34-cycle iterative path above.

## Structure
- `mdu_pkg` holds:
  - `md_op_t` enum (the 3-bit encodings above)
  - `mdu_state_t` enum (IDLE, RUN, FIX, DONE)
  - `MDU_STEPS`=32
  - `MDU_DIVZ_Q`=32'hFFFFFFFF
- Sub-module `div_step`, combinational: one restoring-division step.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new remainder, quotient bit.
  - RUN instantiates it once.

## Test plan
- Reset, then MULT a=32'hFFFFFFFF, b=5 → `done` after 34 cycles (2 with macro), hi=32'hFFFFFFFF, lo=32'hFFFFFFFB.
- MULTU a=b=32'hFFFFFFFF → hi=32'hFFFFFFFE, lo=32'h00000001. `busy` is high for exactly 34 cycles.
- DIV a=-7, b=2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIV a=32'h80000000, b=32'hFFFFFFFF → lo=32'h80000000, hi=0.
- DIVU a=7, b=0 → hi=7, lo=32'hFFFFFFFF. Then MTHI a=32'h1234 → hi=32'h1234 next cycle, lo unchanged, `done` stays 0.
- DIVU 100/7 started; second `start` (MULT) at cycle 10 → ignored; result hi=2, lo=14. Exactly one `done` pulse.
- Reset asserted at cycle 15 of a DIV → next cycle IDLE, `busy`=0, hi=lo=0. A new DIVU 9/3 completes with lo=3, hi=0.
